// File: rtl/load_resp_if.sv
// load_resp_if: load request, dcache and writeback signals of load_resp_unit.
// When LOAD_MISALIGN_CHECK_EN is defined the ld_misaligned flag is added.
// slave is the unit's view; master is the view of whatever drives the loads
// and models the dcache.
interface load_resp_if;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_addr;
  logic [2:0]  ld_funct3;
  logic [4:0]  ld_rd;
  logic        dcache_re;
  logic [31:0] dcache_addr;
  logic        dcache_stall;
  logic [31:0] dcache_dout;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
`ifdef LOAD_MISALIGN_CHECK_EN
  logic        ld_misaligned;

  modport master (
    output ld_valid, ld_addr, ld_funct3, ld_rd, dcache_stall, dcache_dout,
    input  ld_ready, dcache_re, dcache_addr, wb_valid, wb_rd, wb_data, ld_misaligned
  );

  modport slave (
    input  ld_valid, ld_addr, ld_funct3, ld_rd, dcache_stall, dcache_dout,
    output ld_ready, dcache_re, dcache_addr, wb_valid, wb_rd, wb_data, ld_misaligned
  );
`else
  modport master (
    output ld_valid, ld_addr, ld_funct3, ld_rd, dcache_stall, dcache_dout,
    input  ld_ready, dcache_re, dcache_addr, wb_valid, wb_rd, wb_data
  );

  modport slave (
    input  ld_valid, ld_addr, ld_funct3, ld_rd, dcache_stall, dcache_dout,
    output ld_ready, dcache_re, dcache_addr, wb_valid, wb_rd, wb_data
  );
`endif
endinterface

// File: rtl/load_resp_unit.sv
// load_resp_unit: single-outstanding load unit. Accepts one load, reads the
// word from the dcache, extracts/extends the addressed byte/half/word and
// emits a one-cycle writeback strobe.
// Optional feature macro: LOAD_MISALIGN_CHECK_EN (alignment check on accept,
// misaligned loads bypass the dcache and raise ld_misaligned in WB).
//
// state | meaning
// IDLE  | ready for a new load
// REQ   | dcache read request driven, waiting for it to be taken
// RESP  | waiting for read data, address held
// WB    | one-cycle writeback (or misalignment report)
module load_resp_unit (
  input logic        clk,
  input logic        rst,
  load_resp_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [1:0] WB   = 2'd3;

  logic [1:0]  state;
  logic [1:0]  off_q;
  logic [2:0]  funct3_q;
  logic [4:0]  rd_q;
  logic [31:0] dcache_addr_q;
  logic [31:0] wb_data_q;
  logic [4:0]  wb_rd_q;
  logic        misalign_q;
  logic        misalign_in;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

`ifdef LOAD_MISALIGN_CHECK_EN
  // Alignment of the incoming request; unknown funct3 codes behave as LW.
  always_comb begin
    misalign_in = 1'b0;
    case (bus.ld_funct3)
      3'b000, 3'b100: misalign_in = 1'b0;
      3'b001, 3'b101: misalign_in = bus.ld_addr[0];
      default:        misalign_in = |bus.ld_addr[1:0];
    endcase
  end
`else
  assign misalign_in = 1'b0;
`endif

  // Select and extend the addressed field of the returned word.
  always_comb begin
    byte_sel  = bus.dcache_dout[7:0];
    half_sel  = bus.dcache_dout[15:0];
    load_data = bus.dcache_dout;
    case (off_q)
      2'd1:    byte_sel = bus.dcache_dout[15:8];
      2'd2:    byte_sel = bus.dcache_dout[23:16];
      2'd3:    byte_sel = bus.dcache_dout[31:24];
      default: byte_sel = bus.dcache_dout[7:0];
    endcase
    if (off_q[1]) half_sel = bus.dcache_dout[31:16];
    case (funct3_q)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_data = {24'h0, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_data = {16'h0, half_sel};
      default: load_data = bus.dcache_dout;
    endcase
  end

  // Load sequencing; wb_data/wb_rd only change on the RESP->WB transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      off_q         <= 2'd0;
      funct3_q      <= 3'd0;
      rd_q          <= 5'd0;
      dcache_addr_q <= 32'h0;
      wb_data_q     <= 32'h0;
      wb_rd_q       <= 5'd0;
      misalign_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.ld_valid) begin
            off_q      <= bus.ld_addr[1:0];
            funct3_q   <= bus.ld_funct3;
            rd_q       <= bus.ld_rd;
            misalign_q <= misalign_in;
            if (misalign_in) begin
              state <= WB;
            end else begin
              dcache_addr_q <= {bus.ld_addr[31:2], 2'b00};
              state         <= REQ;
            end
          end
        end
        REQ: begin
          if (!bus.dcache_stall) state <= RESP;
        end
        RESP: begin
          if (!bus.dcache_stall) begin
            wb_data_q <= load_data;
            wb_rd_q   <= rd_q;
            state     <= WB;
          end
        end
        WB:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ld_ready    = (state == IDLE);
  assign bus.dcache_re   = (state == REQ);
  assign bus.dcache_addr = dcache_addr_q;
  assign bus.wb_valid    = (state == WB) && !misalign_q;
  assign bus.wb_rd       = wb_rd_q;
  assign bus.wb_data     = wb_data_q;
`ifdef LOAD_MISALIGN_CHECK_EN
  assign bus.ld_misaligned = (state == WB) && misalign_q;
`endif

endmodule

// File: tb/tb_load_resp_unit.sv
// tb_load_resp_unit: builds a cycle timeline of stimulus and expected outputs
// from load transactions (accept, stall counts, returned word), then replays
// it into load_resp_unit and compares every cycle. Directed loads carry
// hand-computed wb_data literals in addition to the model value.
module tb_load_resp_unit;
  localparam int N = 4096;

  logic clk;
  logic rst;
  load_resp_if bus();

  load_resp_unit dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stimulus per cycle
  bit          s_valid [N];
  logic [31:0] s_addr  [N];
  logic [2:0]  s_f3    [N];
  logic [4:0]  s_rd    [N];
  bit          s_stall [N];
  logic [31:0] s_dout  [N];
  bit          s_rst   [N];
  // expected outputs per cycle
  bit          e_ready [N];
  bit          e_re    [N];
  bit          e_wbv   [N];
  bit          e_mis   [N];
  bit          e_achk  [N];
  logic [31:0] e_addr  [N];
  logic [31:0] e_wbd   [N];
  logic [4:0]  e_wbr   [N];
  bit          e_litc  [N];
  logic [31:0] e_lit   [N];

  int          gc;
  logic [31:0] m_data;
  logic [4:0]  m_rd;
  bit          addr_zero;
  int          total;
  int          bad;

  function automatic logic [31:0] extract(input logic [2:0] f, input logic [1:0] off,
                                          input logic [31:0] d);
    logic [31:0] sh;
    case (f)
      3'b000: begin sh = d >> (8 * int'(off));    return {{24{sh[7]}}, sh[7:0]}; end
      3'b100: begin sh = d >> (8 * int'(off));    return {24'h0, sh[7:0]}; end
      3'b001: begin sh = d >> (16 * int'(off[1])); return {{16{sh[15]}}, sh[15:0]}; end
      3'b101: begin sh = d >> (16 * int'(off[1])); return {16'h0, sh[15:0]}; end
      default: return d;
    endcase
  endfunction

`ifdef LOAD_MISALIGN_CHECK_EN
  function automatic bit is_mis(input logic [2:0] f, input logic [1:0] off);
    if (f == 3'b000 || f == 3'b100) return 1'b0;
    if (f == 3'b001 || f == 3'b101) return off[0];
    return off != 2'b00;
  endfunction
`endif

  task automatic emit(input bit v, input logic [31:0] a, input logic [2:0] f,
                      input logic [4:0] r, input bit st, input logic [31:0] d,
                      input bit rs, input bit er, input bit ere, input bit ewv,
                      input bit emis, input bit achk, input logic [31:0] ea);
    s_valid[gc] = v;   s_addr[gc] = a;  s_f3[gc] = f;   s_rd[gc] = r;
    s_stall[gc] = st;  s_dout[gc] = d;  s_rst[gc] = rs;
    e_ready[gc] = er;  e_re[gc] = ere;  e_wbv[gc] = ewv; e_mis[gc] = emis;
    e_achk[gc]  = achk; e_addr[gc] = ea;
    e_wbd[gc]   = m_data; e_wbr[gc] = m_rd;
    gc++;
  endtask

  // busy cycle: request inputs are noise that the unit must ignore
  task automatic busy(input bit st, input logic [31:0] d, input bit rs, input bit ere,
                      input bit ewv, input bit emis, input bit achk, input logic [31:0] ea);
    emit(1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 7)), 5'($urandom),
         st, d, rs, 1'b0, ere, ewv, emis, achk, ea);
  endtask

  task automatic idle();
    emit(1'b0, $urandom, 3'($urandom_range(0, 7)), 5'($urandom), 1'($urandom_range(0, 1)),
         $urandom, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, addr_zero, 32'h0);
  endtask

  // reset while idle, with a request present that must not be captured
  task automatic rst_idle();
    emit(1'b1, $urandom, 3'($urandom_range(0, 7)), 5'($urandom), 1'($urandom_range(0, 1)),
         $urandom, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, addr_zero, 32'h0);
    m_data = 32'h0; m_rd = 5'd0; addr_zero = 1'b1;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [2:0] f, input logic [4:0] r,
                         input logic [31:0] d, input int s1, input int s2, input bit rst_resp,
                         input bit litc, input logic [31:0] lit);
    logic [31:0] wa;
    bit          mis;
    wa  = {a[31:2], 2'b00};
    mis = 1'b0;
`ifdef LOAD_MISALIGN_CHECK_EN
    mis = is_mis(f, a[1:0]);
`endif
    emit(1'b1, a, f, r, 1'($urandom_range(0, 1)), $urandom, 1'b0,
         1'b1, 1'b0, 1'b0, 1'b0, addr_zero, 32'h0);
    addr_zero = 1'b0;
    if (mis) begin
      busy(1'($urandom_range(0, 1)), $urandom, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      return;
    end
    for (int i = 0; i <= s1; i++)
      busy(i < s1, $urandom, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, wa);
    for (int i = 0; i <= s2; i++) begin
      if (i == s2 && rst_resp) begin
        busy(1'b0, d, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, wa);
        m_data = 32'h0; m_rd = 5'd0; addr_zero = 1'b1;
        return;
      end
      busy(i < s2, (i == s2) ? d : $urandom, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, wa);
    end
    m_data = extract(f, a[1:0], d);
    m_rd   = r;
    e_litc[gc] = litc;
    e_lit[gc]  = lit;
    busy(1'($urandom_range(0, 1)), $urandom, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic apply(input int c);
    rst              = s_rst[c];
    bus.ld_valid     = s_valid[c];
    bus.ld_addr      = s_addr[c];
    bus.ld_funct3    = s_f3[c];
    bus.ld_rd        = s_rd[c];
    bus.dcache_stall = s_stall[c];
    bus.dcache_dout  = s_dout[c];
  endtask

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %h want %h", nm, c, act, exp);
    end
  endtask

  initial begin
    int g;
    total = 0; bad = 0; gc = 0;
    m_data = 32'h0; m_rd = 5'd0; addr_zero = 1'b1;
    for (int i = 0; i < N; i++) begin e_litc[i] = 1'b0; e_lit[i] = 32'h0; end

    rst_idle(); rst_idle(); rst_idle();
    idle();
    do_load(32'h0000_1000, 3'b010, 5'd1, 32'hDEAD_BEEF, 0, 0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    idle();
    do_load(32'h0000_1003, 3'b000, 5'd2, 32'h80FF_0011, 0, 0, 1'b0, 1'b1, 32'hFFFF_FF80);
    do_load(32'h0000_1003, 3'b100, 5'd3, 32'h80FF_0011, 0, 0, 1'b0, 1'b1, 32'h0000_0080);
    do_load(32'h0000_2002, 3'b001, 5'd4, 32'h8001_1234, 0, 0, 1'b0, 1'b1, 32'hFFFF_8001);
    do_load(32'h0000_2002, 3'b101, 5'd5, 32'h8001_1234, 0, 0, 1'b0, 1'b1, 32'h0000_8001);
    idle();
    do_load(32'h0000_3000, 3'b010, 5'd6, 32'h1234_5678, 2, 1, 1'b0, 1'b1, 32'h1234_5678);
    do_load(32'h0000_4000, 3'b010, 5'd7, 32'h5555_AAAA, 0, 1, 1'b1, 1'b0, 32'h0);
    idle();
    do_load(32'h0000_1002, 3'b010, 5'd8, 32'hCAFE_F00D, 0, 0, 1'b0, 1'b1, 32'hCAFE_F00D);
    do_load(32'h0000_1000, 3'b111, 5'd9, 32'h0BAD_F00D, 0, 0, 1'b0, 1'b1, 32'h0BAD_F00D);
    rst_idle();

    for (int k = 0; k < 250; k++) begin
      g = $urandom_range(0, 2);
      for (int j = 0; j < g; j++) idle();
      if ($urandom_range(0, 29) == 0) rst_idle();
      do_load($urandom, 3'($urandom_range(0, 7)), 5'($urandom), $urandom,
              ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0,
              ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0,
              $urandom_range(0, 24) == 0, 1'b0, 32'h0);
    end
    while (gc < N) idle();

    apply(0);
    fork
      begin
        for (int c = 1; c < N; c++) begin
          @(posedge clk);
          #1;
          apply(c);
        end
      end
      begin
        #7;
        for (int c = 1; c < N; c++) begin
          @(negedge clk);
          chk("ld_ready", c, 32'(bus.ld_ready), 32'(e_ready[c]));
          chk("dcache_re", c, 32'(bus.dcache_re), 32'(e_re[c]));
          chk("wb_valid", c, 32'(bus.wb_valid), 32'(e_wbv[c]));
          chk("wb_data", c, bus.wb_data, e_wbd[c]);
          chk("wb_rd", c, 32'(bus.wb_rd), 32'(e_wbr[c]));
          if (e_achk[c]) chk("dcache_addr", c, bus.dcache_addr, e_addr[c]);
          if (e_litc[c]) chk("wb_data_literal", c, bus.wb_data, e_lit[c]);
`ifdef LOAD_MISALIGN_CHECK_EN
          chk("ld_misaligned", c, 32'(bus.ld_misaligned), 32'(e_mis[c]));
`endif
        end
      end
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
